fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the control unit (decoder).
- Holds the PC, issues word reads to instruction memory over a req/ack/rvalid handshake, and buffers one instruction in an instruction register (IR).
- Presents the IR and its 4-bit opcode field to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes stale fetches.

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from
// instruction memory and holds it in the IR for the decoder.
//
// state | meaning
// IDLE  | first cycle after reset, no request yet
// FETCH | request pc when the IR slot is free
// WAIT  | one request outstanding, waiting on imem_rvalid
module fetch_unit #(
  parameter int AW = 8,
  parameter int IW = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  input  logic          dec_ready,
  output logic [IW-1:0] instr,
  output logic [3:0]    op,
  output logic [AW-1:0] instr_pc
);

  localparam logic [3:0] NOP_OP = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] ir_pc;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic          drop;
  logic          slot_free;
  logic          accept;

  // The slot is free if the IR is empty or is being consumed this cycle, so
  // the response can never find the IR occupied.
  assign slot_free   = !ir_valid || dec_ready;
  assign imem_req    = (state == FETCH) && slot_free;
  assign accept      = imem_req && imem_ack;
  assign imem_addr   = pc;

  assign instr_valid = ir_valid;
  assign instr       = ir;
  assign instr_pc    = ir_pc;
  assign op          = ir_valid ? ir[IW-1 -: 4] : NOP_OP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      ir_pc    <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (ir_valid && dec_ready) begin
        ir_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            ir_valid <= 1'b0;
            // A request accepted alongside the redirect is already stale.
            if (accept) begin
              drop  <= 1'b1;
              state <= WAIT;
            end
          end else if (accept) begin
            fetch_pc <= pc;
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc       <= redirect_pc;
            ir_valid <= 1'b0;
            // Response arriving with the redirect closes the outstanding
            // request; otherwise the late one must be discarded.
            if (imem_rvalid) begin
              drop  <= 1'b0;
              state <= FETCH;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rvalid) begin
            state <= FETCH;
            if (drop) begin
              drop <= 1'b0;
            end else begin
              ir       <= imem_rdata;
              ir_pc    <= fetch_pc;
              ir_valid <= 1'b1;
              pc       <= fetch_pc + 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run
// against an address-stream model of the fetch/redirect rules.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic [15:0] instr;
  logic [3:0]  op;
  logic [7:0]  instr_pc;

  fetch_unit #(.AW(8), .IW(16), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .dec_ready      (dec_ready),
    .instr          (instr),
    .op             (op),
    .instr_pc       (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // memory model and knobs
  logic       dir_mode  = 1'b1;
  logic       ack_rand  = 1'b0;
  logic       ack_force = 1'b0;
  logic       lat_rand  = 1'b0;
  int         lat       = 1;
  logic       mem_busy  = 1'b0;
  int         mem_cnt   = 0;
  logic [7:0] mem_addr  = '0;

  // reference: next address decode should see, plus stall tracking
  logic [7:0]  exp_pc     = '0;
  int          deliveries = 0;
  logic        prev_hold  = 1'b0;
  logic [15:0] prev_instr = '0;
  logic [7:0]  prev_ipc   = '0;

  logic        s_req, s_valid;
  logic [7:0]  s_addr, s_ipc;
  logic [15:0] s_instr;
  logic [3:0]  s_op;
  logic        dr_r, rv_r;

  function automatic logic [15:0] data_of(input logic [7:0] a);
    if (dir_mode) return 16'h1000 + {8'h00, a};
    return {a[3:0], a[7:4], a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input logic dr, input logic rv, input logic [7:0] rpc);
    int l;
    dec_ready      = dr;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    imem_ack       = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = data_of(mem_addr);
        mem_busy    = 1'b0;
      end
    end
    #1;
    if (ack_force)     imem_ack = 1'b1;
    else if (ack_rand) imem_ack = 1'($urandom_range(0, 1));
    else               imem_ack = imem_req;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_op = op; s_ipc = instr_pc;

    chk("op_rule", {28'd0, s_op}, {28'd0, (s_valid ? s_instr[15:12] : 4'hC)});
    if (s_req) begin
      chk("req_slot_free", {31'd0, (!s_valid || dr)}, 32'd1);
      chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
    end
    if (prev_hold) begin
      chk("stall_valid", {31'd0, s_valid}, 32'd1);
      chk("stall_instr", {16'd0, s_instr}, {16'd0, prev_instr});
      chk("stall_pc", {24'd0, s_ipc}, {24'd0, prev_ipc});
    end
    if (rv) begin
      exp_pc = rpc;
    end else if (s_valid && dr) begin
      chk("deliver_pc", {24'd0, s_ipc}, {24'd0, exp_pc});
      chk("deliver_instr", {16'd0, s_instr}, {16'd0, data_of(exp_pc)});
      exp_pc = exp_pc + 8'd1;
      deliveries++;
    end
    prev_hold  = s_valid && !dr && !rv;
    prev_instr = s_instr;
    prev_ipc   = s_ipc;

    if (s_req && imem_ack) begin
      l        = lat_rand ? int'($urandom_range(1, 3)) : lat;
      mem_busy = 1'b1;
      mem_cnt  = l;
      mem_addr = s_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input logic dr);
    int n = 0;
    step(dr, 1'b0, 8'h00);
    while (!s_valid && n < 20) begin
      step(dr, 1'b0, 8'h00);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, s_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, {16'd0, instr}, 32'd0);
    chk({tag, "_ipc"}, {24'd0, instr_pc}, 32'd0);
    chk({tag, "_op"}, {28'd0, op}, 32'hC);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_busy = 1'b0; mem_cnt = 0; exp_pc = '0; prev_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // first request one cycle after release, then three sequential words
    step(1'b1, 1'b0, 8'h00);
    chk("idle_req", {31'd0, s_req}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("first_req", {31'd0, s_req}, 32'd1);
    chk("first_addr", {24'd0, s_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("gap_valid", {31'd0, s_valid}, 32'd0);
      chk("gap_op", {28'd0, s_op}, 32'hC);
      step(1'b1, 1'b0, 8'h00);
      chk("seq_valid", {31'd0, s_valid}, 32'd1);
      chk("seq_instr", {16'd0, s_instr}, 32'h1000 + i);
      chk("seq_ipc", {24'd0, s_ipc}, i);
      chk("seq_op", {28'd0, s_op}, 32'h1);
    end
    step(1'b1, 1'b0, 8'h00);

    // decode stall with pc 3 in the IR
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00);
      chk("stall3_instr", {16'd0, s_instr}, 32'h1003);
      chk("stall3_ipc", {24'd0, s_ipc}, 32'd3);
      chk("stall3_noreq", {31'd0, s_req}, 32'd0);
    end
    step(1'b1, 1'b0, 8'h00);
    chk("resume_req", {31'd0, s_req}, 32'd1);
    chk("resume_addr", {24'd0, s_addr}, 32'd4);
    step(1'b1, 1'b0, 8'h00);

    // redirect while the fetch of 5 is outstanding
    lat = 2;
    step(1'b1, 1'b0, 8'h00);
    chk("addr5_req", {31'd0, s_req}, 32'd1);
    chk("addr5_addr", {24'd0, s_addr}, 32'd5);
    step(1'b1, 1'b1, 8'h40);
    lat = 1;
    step(1'b1, 1'b0, 8'h00);
    chk("drop5_valid", {31'd0, s_valid}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("after_drop_valid", {31'd0, s_valid}, 32'd0);
    chk("redir40_req", {31'd0, s_req}, 32'd1);
    chk("redir40_addr", {24'd0, s_addr}, 32'h40);
    wait_valid("redir40", 1'b1);
    chk("redir40_ipc", {24'd0, s_ipc}, 32'h40);

    // redirect flushing a stalled IR (spurious ack must be ignored)
    wait_valid("stall41", 1'b0);
    chk("stall41_ipc", {24'd0, s_ipc}, 32'h41);
    ack_force = 1'b1;
    step(1'b0, 1'b1, 8'h80);
    ack_force = 1'b0;
    chk("flush_noreq", {31'd0, s_req}, 32'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("flush_valid", {31'd0, s_valid}, 32'd0);
    chk("redir80_req", {31'd0, s_req}, 32'd1);
    chk("redir80_addr", {24'd0, s_addr}, 32'h80);
    step(1'b1, 1'b0, 8'h00);

    // redirect coincident with an accepted request
    lat = 3;
    step(1'b1, 1'b1, 8'h90);
    chk("ack_redir_ipc", {24'd0, s_ipc}, 32'h80);
    chk("ack_redir_req", {31'd0, s_req}, 32'd1);
    lat = 1;
    begin
      int n = 0;
      step(1'b1, 1'b0, 8'h00);
      while (!s_req && n < 8) begin
        chk("ack_drop_valid", {31'd0, s_valid}, 32'd0);
        step(1'b1, 1'b0, 8'h00);
        n++;
      end
    end
    chk("redir90_req", {31'd0, s_req}, 32'd1);
    chk("redir90_addr", {24'd0, s_addr}, 32'h90);
    wait_valid("redir90", 1'b1);
    chk("redir90_ipc", {24'd0, s_ipc}, 32'h90);

    // PC wrap
    step(1'b1, 1'b1, 8'hFF);
    wait_valid("wrapff", 1'b1);
    chk("wrapff_ipc", {24'd0, s_ipc}, 32'hFF);
    chk("wrapff_instr", {16'd0, s_instr}, 32'h10FF);
    wait_valid("wrap00", 1'b1);
    chk("wrap00_ipc", {24'd0, s_ipc}, 32'h00);
    chk("wrap00_instr", {16'd0, s_instr}, 32'h1000);
    lat = 3;
    wait_valid("wrap01", 1'b1);
    chk("wrap01_ipc", {24'd0, s_ipc}, 32'h01);

    // asynchronous reset in the middle of WAIT
    step(1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");

    // randomized run
    lat = 1;
    dir_mode = 1'b0;
    do_reset();
    ack_rand = 1'b1;
    lat_rand = 1'b1;
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      dr_r = ($urandom_range(0, 9) < 7);
      rv_r = (i > 0) && ($urandom_range(0, 19) == 0);
      step(dr_r, rv_r, 8'($urandom));
    end
    chk("random_progress", {31'd0, (deliveries > 100)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
